ram8_stack_ctrl: RTL
====================

// Module: ram8_stack_ctrl
// PURPOSE
//  Initiator/controller side of the 8x32 RAM port (en/rw/address/in/out). Converts push/pop/peek/clear
//  requests from the expression evaluator into single-cycle RAM accesses, maintaining an 8-deep LIFO.
//  Owns the stack pointer and full/empty state; the RAM itself stays a plain storage array.
// PARAMETERS
//  DATA_W  32  data width; must match the RAM word width
//  DEPTH   8   number of RAM words (LIFO capacity)
//  ADDR_W  3   RAM address width, equal to log2(DEPTH)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       controller accepts request (handshake when req_valid & req_ready at edge)
//  req_op     in   2       00 PUSH, 01 POP, 10 PEEK, 11 CLEAR
//  req_data   in   DATA_W  PUSH operand
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       consumer accepts response
//  rsp_data   out  DATA_W  POP/PEEK result; 0 for PUSH/CLEAR/error
//  rsp_err    out  1       1 = overflow (PUSH when full) or underflow (POP/PEEK when empty)
//  count      out  ADDR_W+1  entries held, 0..DEPTH
//  full       out  1       count == DEPTH
//  empty      out  1       count == 0
//  mem_en     out  1       RAM enable (drives RAM en)
//  mem_rw     out  1       1 = write, 0 = read (drives RAM rw)
//  mem_addr   out  ADDR_W  RAM address
//  mem_wdata  out  DATA_W  RAM write data (drives RAM in)
//  mem_rdata  in   DATA_W  RAM read data (RAM out); combinational, valid in the same cycle as mem_en & !mem_rw
// BEHAVIOUR
//  Reset: state=IDLE, count=0, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, mem_en=0, mem_rw=0,
//    mem_addr=0, mem_wdata=0. RAM contents are not cleared; count=0 makes them unreachable.
//  FSM IDLE -> ACCESS -> RESP -> IDLE. req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
//  IDLE: on handshake, latch op/data, go to ACCESS. Error ops skip the RAM and go straight to RESP, with rsp_err=1.
//  ACCESS (exactly one cycle, mem_en=1):
//    PUSH: mem_rw=1, mem_addr=count[ADDR_W-1:0], mem_wdata=latched data; count+1 at exit edge.
//    POP:  mem_rw=0, mem_addr=count-1; rsp_data<=mem_rdata at exit edge; count-1.
//    PEEK: same as POP, count unchanged.
//    CLEAR: mem_en=0, count<=0; never an error.
//  RESP: hold rsp_* stable until rsp_ready; at handshake go to IDLE, rsp_valid->0.
//  Latency: request accept -> rsp_valid in 2 cycles (RAM op), or 1 cycle (error path).
//  Max throughput: one op per 3 cycles with rsp_ready held high.
//  mem_en=0 in every state except ACCESS; mem_addr/mem_wdata hold their last value when idle.
//  Boundaries:
//    - PUSH at count=DEPTH-1 fills the last slot (addr 7) and sets full.
//    - PUSH at full: err, no write.
//    - POP at count=1 reads addr 0 and sets empty.
//    - No wrap-around; count saturates by rejection.
//  rst in any state (including mid-ACCESS) wins: return to reset values next edge;
//    any write in that cycle is blocked because mem_en is forced 0 while rst=1.
//  full/empty/count are registered and change only at the ACCESS exit edge (or CLEAR).
// STRUCTURE
//  Shared package (stack_pkg):
//    - op codes OP_PUSH/OP_POP/OP_PEEK/OP_CLEAR
//    - state encoding S_IDLE/S_ACCESS/S_RESP
//    - DATA_W/DEPTH defaults
//  Single module; no sub-module needed. The RAM is instantiated by the parent, not inside this block.
// TESTING
//  Bench pairs the controller with an 8x32 RAM model (combinational read, write on clk when en&rw).
//  1. PUSH 0x11111111..0x88888888, then POP x8 -> data returns 0x88888888 first down to 0x11111111;
//     err=0 throughout; full after the 8th push; empty after the 8th pop.
//  2. Full stack, PUSH 0xDEADBEEF -> rsp_err=1 after 1 cycle, no mem_en pulse; PEEK returns 0x88888888.
//  3. Empty stack, POP and PEEK -> rsp_err=1, rsp_data=0, count stays 0, no RAM access.
//  4. PUSH 0xA5A5A5A5, PEEK twice -> 0xA5A5A5A5 both times, count=1;
//     CLEAR -> count=0, empty=1, then POP -> err.
//  5. Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data held stable, req_ready=0;
//     req_valid held throughout, accepted only after return to IDLE.
//  6. Assert rst during ACCESS of a PUSH -> no RAM write, next cycle count=0, req_ready=1, rsp_valid=0.

Source files
------------

// File: rtl/ram8_stack_ctrl_pkg.sv
// Shared definitions for the RAM-backed LIFO controller: operation codes,
// FSM state encoding and default geometry.
package ram8_stack_ctrl_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 8;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_ACCESS = 2'b01;
  localparam logic [1:0] S_RESP   = 2'b10;

endpackage

// File: rtl/ram8_stack_ctrl.sv
// LIFO controller in front of a plain single-port RAM: turns push/pop/peek/clear
// requests into one-cycle RAM accesses and owns the stack pointer.
module ram8_stack_ctrl
  import ram8_stack_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    count_d     = count_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d       = req_op;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = S_ACCESS;
          // Address is prepared here so the ACCESS cycle drives it from a flop.
          case (req_op)
            OP_PUSH: begin
              if (count_q == DEPTH_C) begin
                rsp_err_d = 1'b1;
                state_d   = S_RESP;
              end else begin
                mem_addr_d  = count_q[ADDR_W-1:0];
                mem_wdata_d = req_data;
              end
            end
            OP_POP, OP_PEEK: begin
              if (count_q == '0) begin
                rsp_err_d = 1'b1;
                state_d   = S_RESP;
              end else begin
                mem_addr_d = ADDR_W'(count_q - 1'b1);
              end
            end
            default: ;
          endcase
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        case (op_q)
          OP_PUSH: count_d = count_q + 1'b1;
          OP_POP: begin
            rsp_data_d = mem_rdata;
            count_d    = count_q - 1'b1;
          end
          OP_PEEK:  rsp_data_d = mem_rdata;
          default:  count_d = '0;
        endcase
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_PUSH;
      count_q     <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      count_q     <= count_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // rst gates the strobe combinationally so a reset mid-ACCESS cannot write the RAM.
  assign mem_en    = (state_q == S_ACCESS) && (op_q != OP_CLEAR) && !rst;
  assign mem_rw    = mem_en && (op_q == OP_PUSH);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);

endmodule
